// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative multiply/divide unit with architectural HI/LO registers.
//
// Executes mult/multu/div/divu one radix-2 step per cycle (shift-add multiply,
// restoring divide). It holds the results in HI/LO for mfhi/mflo and accepts
// direct HI/LO writes (mthi/mtlo) while idle.
//
// Optional feature macro: MULDIV_SIGNED_EN
//   defined   : op[1]=1 selects signed two's-complement mult/div
//   undefined : op[1] ignored, every operation is unsigned
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   start        request a new operation (sampled only when idle)
//   op[1:0]      00 multu, 01 divu, 10 mult, 11 div
//   a, b         rs / rt operands
//   hi_we, lo_we mthi / mtlo write enables (idle only, start has priority)
//   wdata        data for hi_we / lo_we
//   busy         operation in progress
//   done         one-cycle pulse after the result is committed
//   div_by_zero  last divide had b == 0 (sticky until next accepted start)
//   hi, lo       HI / LO registers
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg;
    logic                 is_div_reg;
    logic                 dz_pend_reg;     // divide-by-zero operation in flight
    logic [WIDTH-1:0]     operand_reg;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_reg;         // mul: {partial, multiplier}; div: {rem, quo}
    logic                 done_reg;
    logic                 dbz_reg;
    logic [WIDTH-1:0]     hi_reg, lo_reg;

    logic                 accept;
    logic                 commit;
    logic                 b_zero_div;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     res_hi, res_lo;

    assign accept     = (state_reg == IDLE) && start;
    assign b_zero_div = op[0] && (b == '0);
    // A divide-by-zero spends one extra cycle in FINISH so that done lands
    // two edges after accept; normal operations commit on the first FINISH edge.
    assign commit     = (state_reg == FINISH) && !(dz_pend_reg && (cnt_reg == '0));

`ifdef MULDIV_SIGNED_EN
    logic neg_res_reg;   // product / quotient negative
    logic neg_rem_reg;   // remainder negative (dividend sign)
    logic a_neg, b_neg;
    assign a_neg = op[1] && a[WIDTH-1];
    assign b_neg = op[1] && b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;
`else
    logic unused_op_sign;
    assign unused_op_sign = op[1];
    assign a_mag = a;
    assign b_mag = b;
`endif

    // One iteration step of whichever operation is running.
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                    (acc_reg[0] ? {1'b0, operand_reg} : {(WIDTH+1){1'b0}});
        // Shifted remainder (rem << 1 | next dividend bit) minus divisor; the
        // shifted value is always below 2*divisor, so bit WIDTH is the borrow.
        div_trial = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, operand_reg};
        if (is_div_reg) begin
            if (div_trial[WIDTH])
                acc_step = {acc_reg[2*WIDTH-2:WIDTH-1], acc_reg[WIDTH-2:0], 1'b0};
            else
                acc_step = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_reg[WIDTH-1:1]};
        end
    end

    // Final result with signs reapplied.
    always_comb begin
        res_hi = acc_reg[2*WIDTH-1:WIDTH];
        res_lo = acc_reg[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        if (is_div_reg) begin
            if (neg_res_reg) res_lo = ~acc_reg[WIDTH-1:0] + 1'b1;
            if (neg_rem_reg) res_hi = ~acc_reg[2*WIDTH-1:WIDTH] + 1'b1;
        end else if (neg_res_reg) begin
            {res_hi, res_lo} = ~acc_reg + 1'b1;
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = b_zero_div ? FINISH : RUN;
            RUN:     if (cnt_reg == CW'(WIDTH - 1)) state_next = FINISH;
            FINISH:  if (commit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            is_div_reg  <= 1'b0;
            dz_pend_reg <= 1'b0;
            operand_reg <= '0;
            acc_reg     <= '0;
            done_reg    <= 1'b0;
            dbz_reg     <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            done_reg  <= commit;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cnt_reg     <= '0;
                        is_div_reg  <= op[0];
                        dz_pend_reg <= b_zero_div;
                        dbz_reg     <= 1'b0;
                        if (op[0]) begin
                            operand_reg <= b_mag;
                            acc_reg     <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            operand_reg <= a_mag;
                            acc_reg     <= {{WIDTH{1'b0}}, b_mag};
                        end
`ifdef MULDIV_SIGNED_EN
                        neg_res_reg <= a_neg ^ b_neg;
                        neg_rem_reg <= a_neg;
`endif
                    end else begin
                        if (hi_we) hi_reg <= wdata;
                        if (lo_we) lo_reg <= wdata;
                    end
                end
                RUN: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                FINISH: begin
                    if (!commit) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (dz_pend_reg) begin
                        dbz_reg <= 1'b1;
                    end else begin
                        hi_reg <= res_hi;
                        lo_reg <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed testbench for muldiv_hilo (WIDTH=32).
module tb_muldiv_hilo;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    muldiv_hilo #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Launch one operation and follow it to completion.
    // mode 0: plain; 1: re-pulse start and zero a at cycle 5;
    // 2: attempt mthi while busy; 3: lo_we asserted alongside start.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input int exp_lat, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz, input int mode);
        int lat;
        start = 1'b1; op = o; a = av; b = bv;
        if (mode == 3) begin lo_we = 1'b1; wdata = 32'hDEAD; end
        tick();
        start = 1'b0; lo_we = 1'b0;
        check({tag, "_busy_on_accept"}, {63'd0, busy}, 64'd1);
        check({tag, "_dbz_cleared"}, {63'd0, div_by_zero}, 64'd0);
        if (mode == 3) check({tag, "_lo_not_written"}, {32'd0, lo}, {32'd0, model_lo});
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (done) begin lat = k; break; end
            if (mode == 1 && k == 5) begin start = 1'b1; a = 32'd0; end
            if (mode == 1 && k == 6) start = 1'b0;
            if (mode == 2 && k == 3) begin hi_we = 1'b1; wdata = 32'hAAAA_AAAA; end
            if (mode == 2 && k == 4) begin
                hi_we = 1'b0;
                check({tag, "_hi_write_while_busy"}, {32'd0, hi}, {32'd0, model_hi});
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_with_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dz});
        tick();
        check({tag, "_done_single"}, {63'd0, done}, 64'd0);
        check({tag, "_idle_after"}, {63'd0, busy}, 64'd0);
        check({tag, "_dbz_sticky"}, {63'd0, div_by_zero}, {63'd0, exp_dz});
        $display("op %s: op=%b a=%h b=%h latency=%0d hi=%h lo=%h dbz=%b",
                 tag, o, av, bv, lat, hi, lo, div_by_zero);
        model_hi = exp_hi;
        model_lo = exp_lo;
    endtask

    initial begin
        tick(); tick();
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        reset = 1'b0;
        tick();

        // mthi and mtlo in the same cycle
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_0055;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi_mtlo_hi", {32'd0, hi}, 64'h55);
        check("mthi_mtlo_lo", {32'd0, lo}, 64'h55);
        $display("write: hi=%h lo=%h", hi, lo);

        // Reset mid-multiply discards the operation and clears HI/LO
        start = 1'b1; op = 2'b00; a = 32'hFFFF; b = 32'hFFFF;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("midop_reset_hi", {32'd0, hi}, 64'd0);
        check("midop_reset_lo", {32'd0, lo}, 64'd0);
        check("midop_reset_busy", {63'd0, busy}, 64'd0);
        check("midop_reset_done", {63'd0, done}, 64'd0);
        $display("reset mid-op: hi=%h lo=%h busy=%b", hi, lo, busy);
        model_hi = '0; model_lo = '0;
        tick();

        run_op("multu_3x5", 2'b00, 32'd3, 32'd5, 33, 32'd0, 32'd15, 1'b0, 0);
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 2);
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 1);

        hi_we = 1'b1; wdata = 32'h0000_1234;
        tick();
        hi_we = 1'b0;
        check("mthi_1234", {32'd0, hi}, 64'h1234);
        model_hi = 32'h1234;
        run_op("divu_by_zero", 2'b01, 32'd9, 32'd0, 2, 32'h1234, 32'd14, 1'b1, 0);

        run_op("start_beats_mtlo", 2'b00, 32'd6, 32'd7, 33, 32'd0, 32'd42, 1'b0, 3);

`ifdef MULDIV_SIGNED_EN
        run_op("div_neg7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("div_minneg_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0, 0);
        run_op("mult_neg3_5", 2'b10, 32'hFFFF_FFFD, 32'd5, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
`else
        run_op("div_neg7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 33, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 0);
        run_op("div_minneg_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0, 0);
        run_op("mult_neg3_5", 2'b10, 32'hFFFF_FFFD, 32'd5, 33, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
Iterative, parametrised multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It executes mult/multu/div/divu over multiple cycles using a start/busy/done handshake. It holds the results for mfhi/mflo and accepts direct HI/LO writes for mthi/mtlo. It sits beside the ALU, which no longer performs multiply or divide.

Parameters:
WIDTH, 32, operand width and HI/LO register width; must be 2 or greater.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  operation select: 00 multu, 01 divu, 10 mult, 11 div
a  input  WIDTH  operand rs (multiplicand or dividend)
b  input  WIDTH  operand rt (multiplier or divisor)
hi_we  input  1  mthi: write wdata into HI
lo_we  input  1  mtlo: write wdata into LO
wdata  input  WIDTH  data for hi_we/lo_we
busy  output  1  operation in progress
done  output  1  one-cycle pulse when the result is committed
div_by_zero  output  1  last divide had b == 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high): state returns to IDLE. hi=0, lo=0, busy=0, done=0, div_by_zero=0. Any in-flight operation is discarded; reset mid-operation leaves no partial result in HI/LO.
- States are IDLE, RUN and FINISH.
- IDLE, accept: if start=1 at edge N, latch a, b and op; clear div_by_zero; load iteration counter = 0; go to RUN. busy=1 from edge N.
- IDLE, divide by zero: if op[0]=1 and b==0 at accept, go directly to FINISH.
- RUN: one radix-2 iteration per cycle (shift-add multiply, restoring divide) on internal 2*WIDTH accumulators. After WIDTH iterations, at edge N+WIDTH, go to FINISH.
- FINISH, at the next edge:
  - Multiply: {hi,lo} = full 2*WIDTH product.
  - Divide: lo = quotient, hi = remainder.
  - Divide by zero: hi/lo unchanged, div_by_zero=1.
  - In all cases done=1 for exactly one cycle, busy=0, state returns to IDLE.
- Latency: done is high in the cycle after edge N+WIDTH+1 (33 cycles for WIDTH=32). For divide by zero, done follows edge N+2.
- start while busy: ignored; no queueing.
- a/b changes after accept: have no effect on the running operation.
- hi_we/lo_we in IDLE: write at the edge; both may be written in the same cycle.
- hi_we/lo_we while busy or in FINISH: ignored.
- start together with hi_we/lo_we in IDLE: start wins and the writes are dropped.
- hi/lo are stable at all times except on commit and accepted writes; they are registered outputs.
- div_by_zero is sticky until the next accepted start or reset.
- done is never asserted except as above; done and busy are never high together.

Optional Feature:
Macro MULDIV_SIGNED_EN.
- Defined: op[1]=1 selects signed two's-complement operation.
  - Operands are converted to magnitudes at accept and signs are applied at FINISH.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Most-negative / -1 gives lo = most-negative value (wrap) and hi = 0.
  - Latency is unchanged.
- Undefined: op[1] is ignored, all operations are unsigned, and no sign logic is synthesised.

Test Plan:
1. Assert reset for 2 cycles mid-multiply (10 cycles after start) -> hi=0, lo=0, busy=0, done=0. A following multu 3*5 gives lo=15, hi=0.
2. WIDTH=32, multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done pulses exactly once, 33 cycles after the start edge.
3. divu a=100 b=7, with start re-pulsed and a changed to 0 at cycle 5 -> lo=14, hi=2, single done, no second operation.
4. hi_we=1 with wdata=0x1234, then divu a=9 b=0 -> done after 2 cycles, div_by_zero=1, hi=0x1234, lo unchanged. Next accepted start clears div_by_zero.
5. In IDLE, start=1 together with lo_we=1 and wdata=0xDEAD -> lo is not written to 0xDEAD; the operation result lands normally.
6. div a=0xFFFFFFF9 b=2 -> with MULDIV_SIGNED_EN: lo=0xFFFFFFFD, hi=0xFFFFFFFF. Without the macro: lo=0x7FFFFFFC, hi=0x00000001.
